// File: rtl/fifo_wr_pkg.sv
// Shared types and defaults for the FIFO write-side framer.
package fifo_wr_pkg;

  localparam int         FIFO_DATA_W = 16;
  localparam int         FIFO_LEN_W  = 8;
  localparam logic [7:0] FIFO_SYNC   = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_TRAILER = 3'd3,
    ST_DONE    = 3'd4
  } wr_state_e;

endpackage

// File: rtl/fifo_wr_csum.sv
// Running payload checksum: modulo-2^W sum, cleared at frame start.
module fifo_wr_csum #(
  parameter int W = 16
) (
  input  logic         Write_Clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_add,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_sum
);

  logic [W-1:0] r_acc;

  // Accumulate accepted payload words; carry out of the top bit is dropped.
  always_ff @(posedge Write_Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= {W{1'b0}};
    end else if (i_clr) begin
      r_acc <= {W{1'b0}};
    end else if (i_add) begin
      r_acc <= r_acc + i_data;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_sum = r_acc;

endmodule

// File: rtl/fifo_write_framer.sv
// Write-side producer: frames upstream payload as header, payload words and
// checksum trailer, pushing into the FIFO while respecting Full_Flag.
module fifo_write_framer
  import fifo_wr_pkg::*;
#(
  parameter int         DATA_W = FIFO_DATA_W,
  parameter int         LEN_W  = FIFO_LEN_W,
  parameter logic [7:0] SYNC   = FIFO_SYNC
) (
  input  logic              Write_Clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  start_len,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              Full_Flag,
  output logic [DATA_W-1:0] Write_Data,
  output logic              Write_En,
  output logic              Busy,
  output logic              Done,
  output logic [7:0]        Frame_Cnt
);

  wr_state_e         r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_frame_cnt;

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_hdr;
  logic [DATA_W-1:0] w_wd;
  logic              w_we;
  logic              w_rdy;
  logic              w_xfer;
  logic              w_clr;
  logic              w_last;

  assign w_hdr  = DATA_W'({SYNC, r_len});
  assign w_clr  = (r_state == ST_IDLE) && start;
  assign w_xfer = (r_state == ST_PAYLOAD) && src_valid && !Full_Flag;
  // Only evaluated in PAYLOAD, where r_len is known to be non-zero.
  assign w_last = (r_cnt == (r_len - LEN_W'(1)));

  fifo_wr_csum #(.W(DATA_W)) u_csum (
    .Write_Clk (Write_Clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_add     (w_xfer),
    .i_data    (src_data),
    .o_sum     (w_sum)
  );

  // Write strobe, write word and upstream ready decoded from state and Full_Flag.
  always_comb begin
    w_we  = 1'b0;
    w_wd  = {DATA_W{1'b0}};
    w_rdy = 1'b0;
    case (r_state)
      ST_HEADER: begin
        w_we = !Full_Flag;
        w_wd = w_hdr;
      end
      ST_PAYLOAD: begin
        w_rdy = !Full_Flag;
        w_we  = src_valid && !Full_Flag;
        w_wd  = src_data;
      end
      ST_TRAILER: begin
        w_we = !Full_Flag;
        w_wd = w_sum;
      end
      default: begin
        w_we  = 1'b0;
        w_wd  = {DATA_W{1'b0}};
        w_rdy = 1'b0;
      end
    endcase
  end

  assign Write_En   = w_we;
  assign Write_Data = w_we ? w_wd : {DATA_W{1'b0}};
  assign src_ready  = w_rdy;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Frame_Cnt  = r_frame_cnt;

  // Frame sequencer with registered Busy/Done/Frame_Cnt; everything holds while Full_Flag blocks a write.
  always_ff @(posedge Write_Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= {LEN_W{1'b0}};
      r_cnt       <= {LEN_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_len   <= start_len;
            r_cnt   <= {LEN_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (!Full_Flag) begin
            r_state <= (r_len == {LEN_W{1'b0}}) ? ST_TRAILER : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + LEN_W'(1);
            if (w_last) begin
              r_state <= ST_TRAILER;
            end
          end
        end
        ST_TRAILER: begin
          if (!Full_Flag) begin
            r_state     <= ST_DONE;
            r_done      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_framer.sv
// Directed, table-driven bench for fifo_write_framer.
module tb_fifo_write_framer;

  logic        Write_Clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        start     = 1'b0;
  logic [7:0]  start_len = 8'd0;
  logic [15:0] src_data  = 16'd0;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic        Full_Flag = 1'b0;
  logic [15:0] Write_Data;
  logic        Write_En;
  logic        Busy;
  logic        Done;
  logic [7:0]  Frame_Cnt;

  int checks     = 0;
  int failures   = 0;
  int exp_frames = 0;

  always #5 Write_Clk = ~Write_Clk;

  fifo_write_framer dut (
    .Write_Clk  (Write_Clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_len  (start_len),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .Full_Flag  (Full_Flag),
    .Write_Data (Write_Data),
    .Write_En   (Write_En),
    .Busy       (Busy),
    .Done       (Done),
    .Frame_Cnt  (Frame_Cnt)
  );

  // mode: 0 steady, 1 Full_Flag high 4 cycles once stall_at words written,
  //       2 Full_Flag/src_valid toggling, 3 start held high during the frame
  typedef struct {
    logic [7:0]       len;
    logic [3:0][15:0] p;
    int               mode;
    int               stall_at;
    logic [15:0]      hdr;
    logic [15:0]      trl;
    int               edges;   // rising edges from start edge (inclusive) to Done
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    logic [15:0] got [$];
    int  pidx       = 0;
    int  stall_left = 0;
    bit  stalled    = 1'b0;
    int  done_edges = 0;
    bit  bad_full   = 1'b0;
    bit  bad_rdy    = 1'b0;
    bit  bad_xfer   = 1'b0;
    bit  bad_busy   = 1'b0;
    logic [15:0] exp_w;
    int  nexp;
    @(posedge Write_Clk); #1;
    start     = 1'b1;
    start_len = v.len;
    Full_Flag = 1'b0;
    src_valid = 1'b0;
    @(posedge Write_Clk); #1;
    if (v.mode == 3) begin
      start     = 1'b1;
      start_len = 8'h09;
    end else begin
      start = 1'b0;
    end
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (v.mode == 1 && !stalled && got.size() == v.stall_at) begin
        stall_left = 4;
        stalled    = 1'b1;
      end
      case (v.mode)
        1:       Full_Flag = (stall_left > 0);
        2:       Full_Flag = cyc[0];
        default: Full_Flag = 1'b0;
      endcase
      src_valid = (v.mode == 2) ? !cyc[1] : 1'b1;
      src_data  = (pidx < 4) ? v.p[pidx] : 16'hDEAD;
      @(negedge Write_Clk);
      if (Done) begin
        done_edges = cyc + 1;
        start      = 1'b0;
        break;
      end
      if (!Busy) bad_busy = 1'b1;
      if (Full_Flag && (Write_En || src_ready)) bad_full = 1'b1;
      if (v.len == 8'd0 && src_ready) bad_rdy = 1'b1;
      if (src_ready && (Write_En != src_valid)) bad_xfer = 1'b1;
      if (Write_En) got.push_back(Write_Data);
      if (src_ready && src_valid) pidx++;
      if (stall_left > 0) stall_left--;
      @(posedge Write_Clk); #1;
    end
    start = 1'b0;
    nexp  = int'(v.len) + 2;
    chk($sformatf("v%0d word_count", idx), got.size(), nexp);
    for (int i = 0; i < nexp && i < got.size(); i++) begin
      if (i == 0)             exp_w = v.hdr;
      else if (i == nexp - 1) exp_w = v.trl;
      else                    exp_w = v.p[i-1];
      chk($sformatf("v%0d word%0d", idx, i), got[i], exp_w);
    end
    chk($sformatf("v%0d done_edges", idx), done_edges, v.edges);
    chk($sformatf("v%0d write_while_full", idx), bad_full, 1'b0);
    chk($sformatf("v%0d busy_in_frame", idx), bad_busy, 1'b0);
    chk($sformatf("v%0d xfer_rule", idx), bad_xfer, 1'b0);
    if (v.len == 8'd0) chk($sformatf("v%0d src_ready_empty", idx), bad_rdy, 1'b0);
    exp_frames++;
    @(posedge Write_Clk); #1;
    chk($sformatf("v%0d frame_cnt", idx), Frame_Cnt, exp_frames % 256);
    chk($sformatf("v%0d busy_after", idx), Busy, 1'b0);
  endtask

  initial begin
    vec_t rv;
    int   n;
    int   dn;
    int   last;
    int   gap_bad;

    vecs[0] = '{len: 8'd3, p: {16'h0000, 16'h0003, 16'h0002, 16'h0001}, mode: 0, stall_at: 0,
                hdr: 16'hA503, trl: 16'h0006, edges: 6};
    vecs[1] = '{len: 8'd0, p: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, mode: 0, stall_at: 0,
                hdr: 16'hA500, trl: 16'h0000, edges: 3};
    vecs[2] = '{len: 8'd2, p: {16'h0000, 16'h0000, 16'h0F0F, 16'h1234}, mode: 1, stall_at: 2,
                hdr: 16'hA502, trl: 16'h2143, edges: 9};
    vecs[3] = '{len: 8'd2, p: {16'h0000, 16'h0000, 16'h0002, 16'hFFFF}, mode: 0, stall_at: 0,
                hdr: 16'hA502, trl: 16'h0001, edges: 5};
    vecs[4] = '{len: 8'd2, p: {16'h0000, 16'h0000, 16'h0020, 16'h0010}, mode: 2, stall_at: 0,
                hdr: 16'hA502, trl: 16'h0030, edges: 12};
    vecs[5] = '{len: 8'd4, p: {16'h0001, 16'h7FFF, 16'h8000, 16'h8000}, mode: 0, stall_at: 0,
                hdr: 16'hA504, trl: 16'h8000, edges: 7};
    vecs[6] = '{len: 8'd3, p: {16'h0000, 16'h0007, 16'h0006, 16'h0005}, mode: 3, stall_at: 0,
                hdr: 16'hA503, trl: 16'h0012, edges: 6};

    // Reset state
    #12;
    chk("rst Write_En", Write_En, 1'b0);
    chk("rst Write_Data", Write_Data, 16'h0000);
    chk("rst src_ready", src_ready, 1'b0);
    chk("rst Busy", Busy, 1'b0);
    chk("rst Done", Done, 1'b0);
    chk("rst Frame_Cnt", Frame_Cnt, 8'd0);
    @(negedge Write_Clk);
    rst_n = 1'b1;

    // Reset asserted mid-payload abandons the frame
    @(posedge Write_Clk); #1;
    start = 1'b1; start_len = 8'd5; src_valid = 1'b1; src_data = 16'h1111;
    @(posedge Write_Clk); #1;
    start = 1'b0;
    @(posedge Write_Clk); #1;
    @(posedge Write_Clk); #1;
    chk("midrst busy_before", Busy, 1'b1);
    chk("midrst we_before", Write_En, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst Write_En", Write_En, 1'b0);
    chk("midrst Busy", Busy, 1'b0);
    chk("midrst src_ready", src_ready, 1'b0);
    chk("midrst Frame_Cnt", Frame_Cnt, 8'd0);
    @(negedge Write_Clk);
    rst_n = 1'b1;
    rv = '{len: 8'd1, p: {16'h0000, 16'h0000, 16'h0000, 16'h0042}, mode: 0, stall_at: 0,
           hdr: 16'hA501, trl: 16'h0042, edges: 4};
    run_frame(rv, 99);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], i);
    end

    // Back-to-back empty frames until Frame_Cnt wraps to zero
    n       = 256 - (exp_frames % 256);
    dn      = 0;
    last    = -1;
    gap_bad = 0;
    @(posedge Write_Clk); #1;
    start = 1'b1; start_len = 8'd0; Full_Flag = 1'b0; src_valid = 1'b0;
    for (int c = 0; c < n * 4 + 40 && dn < n; c++) begin
      @(negedge Write_Clk);
      if (Done) begin
        if (last >= 0 && c - last != 4) gap_bad++;
        last = c;
        dn++;
      end
    end
    start = 1'b0;
    @(posedge Write_Clk); #1;
    chk("b2b frames_done", dn, n);
    chk("b2b period", gap_bad, 0);
    chk("b2b Frame_Cnt_wrap", Frame_Cnt, 8'd0);
    chk("b2b Busy_idle", Busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
